// File: rtl/stream_drv_pkg.sv
// Shared definitions for the stream host driver.
//
// Holds the FSM state encoding, the default payload width and packet
// lengths, and the fixed buffer address widths used by the driver and
// its memories. DEF_TIMEOUT_CYCLES exists only when the optional
// watchdog (macro STREAM_DRV_TIMEOUT_EN) is enabled.
package stream_drv_pkg;

    localparam int DEF_WIDTH        = 8;
    localparam int DEF_NUM_TX_WORDS = 467;
    localparam int DEF_NUM_RX_WORDS = 64;
    localparam int TX_ADDR_BITS     = 9;
    localparam int RX_ADDR_BITS     = 6;
    localparam int AXIS_DATA_BITS   = 32;

`ifdef STREAM_DRV_TIMEOUT_EN
    localparam int DEF_TIMEOUT_CYCLES = 1024;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        RECV   = 2'd2,
        FINISH = 2'd3
    } drv_state_t;

endpackage

// File: rtl/memory_RAM.sv
// Simple dual-port synchronous RAM.
//
// Ports:
//   clock        write/read clock
//   we           write enable
//   waddr, wdata write port
//   raddr        read address, sampled on the clock edge
//   rdata        registered read data (one cycle after raddr)
// Contents are not reset.
module memory_RAM #(
    parameter int data_width = 8,
    parameter int depth_bits = 9
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [depth_bits-1:0] waddr,
    input  logic [data_width-1:0] wdata,
    input  logic [depth_bits-1:0] raddr,
    output logic [data_width-1:0] rdata
);

    logic [data_width-1:0] mem [2**depth_bits];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/stream_host_driver.sv
// Stream host driver: sends a buffered packet on an AXI-Stream master
// port, then collects a fixed-length reply packet into a result buffer.
//
// Ports:
//   ACLK, ARESETN          clock, synchronous active-low reset
//   start                  pulse in IDLE begins a transaction
//   busy, done, error      status (done is a one-cycle pulse, error is
//                          sticky until the next accepted start)
//   ld_we/ld_addr/ld_data  TX buffer load port, ignored while busy
//   rd_addr/rd_data        RX buffer read port, one-cycle latency
//   M_AXIS_*               outgoing packet (NUM_TX_WORDS words)
//   S_AXIS_*               returned packet (NUM_RX_WORDS words)
//
// Optional feature: define STREAM_DRV_TIMEOUT_EN to add a watchdog
// (parameter TIMEOUT_CYCLES) that aborts SEND/RECV after that many
// consecutive cycles without a handshake.
module stream_host_driver
    import stream_drv_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int NUM_TX_WORDS = DEF_NUM_TX_WORDS,
    parameter int NUM_RX_WORDS = DEF_NUM_RX_WORDS
`ifdef STREAM_DRV_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    input  logic                      ld_we,
    input  logic [TX_ADDR_BITS-1:0]   ld_addr,
    input  logic [WIDTH-1:0]          ld_data,
    input  logic [RX_ADDR_BITS-1:0]   rd_addr,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      M_AXIS_TVALID,
    output logic [AXIS_DATA_BITS-1:0] M_AXIS_TDATA,
    output logic                      M_AXIS_TLAST,
    input  logic                      M_AXIS_TREADY,
    input  logic                      S_AXIS_TVALID,
    input  logic [AXIS_DATA_BITS-1:0] S_AXIS_TDATA,
    input  logic                      S_AXIS_TLAST,
    output logic                      S_AXIS_TREADY
);

    // One extra bit so the issue pointer can reach NUM_TX_WORDS.
    localparam int TX_CNT_BITS = TX_ADDR_BITS + 1;
    localparam logic [TX_CNT_BITS-1:0]  TX_END  = TX_CNT_BITS'(NUM_TX_WORDS);
    localparam logic [TX_CNT_BITS-1:0]  TX_LAST = TX_CNT_BITS'(NUM_TX_WORDS - 1);
    localparam logic [RX_ADDR_BITS-1:0] RX_LAST = RX_ADDR_BITS'(NUM_RX_WORDS - 1);

`ifdef STREAM_DRV_TIMEOUT_EN
    localparam int WD_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_BITS-1:0] WD_LIMIT = WD_BITS'(TIMEOUT_CYCLES - 1);
    logic [WD_BITS-1:0] wd_count;
`endif

    drv_state_t state;

    // TX prefetch: issue_ptr walks the buffer, inflight marks a RAM read
    // whose data appears on tx_rdata this cycle. head is the word on the
    // master port, skid catches a read that lands while head is stalled.
    logic [TX_CNT_BITS-1:0] issue_ptr;
    logic                   inflight;
    logic                   inflight_last;
    logic                   head_valid;
    logic                   head_last;
    logic [WIDTH-1:0]       head_data;
    logic                   skid_valid;
    logic                   skid_last;
    logic [WIDTH-1:0]       skid_data;
    logic [WIDTH-1:0]       tx_rdata;

    logic [RX_ADDR_BITS-1:0] rx_count;
    logic                    s_ready;

    logic       m_pop;
    logic       s_take;
    logic       issue;
    logic [1:0] pending;

    // Upper stream bits carry no payload.
    logic unused_tdata;
    assign unused_tdata = ^S_AXIS_TDATA;

    assign M_AXIS_TVALID = head_valid;
    assign M_AXIS_TLAST  = head_last;
    assign M_AXIS_TDATA  = AXIS_DATA_BITS'(head_data);
    assign S_AXIS_TREADY = s_ready;

    // A new read is issued only if the buffer can absorb it: words held
    // plus reads in flight, minus the word leaving now, must stay below 2.
    always_comb begin
        m_pop   = head_valid && M_AXIS_TREADY;
        s_take  = s_ready && S_AXIS_TVALID;
        pending = {1'b0, head_valid} + {1'b0, skid_valid} + {1'b0, inflight};
        issue   = (state == SEND) && (issue_ptr != TX_END) &&
                  ((pending < 2'd2) || (m_pop && (pending == 2'd2)));
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            issue_ptr     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            head_valid    <= 1'b0;
            head_last     <= 1'b0;
            head_data     <= '0;
            skid_valid    <= 1'b0;
            skid_last     <= 1'b0;
            skid_data     <= '0;
            rx_count      <= '0;
            s_ready       <= 1'b0;
`ifdef STREAM_DRV_TIMEOUT_EN
            wd_count      <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SEND;
                        busy      <= 1'b1;
                        error     <= 1'b0;
                        issue_ptr <= '0;
                        rx_count  <= '0;
                    end
                end

                SEND: begin
                    if (issue) begin
                        issue_ptr <= issue_ptr + 1'b1;
                    end
                    inflight      <= issue;
                    inflight_last <= (issue_ptr == TX_LAST);

                    if (m_pop && head_last) begin
                        // Final word accepted; nothing else can be pending.
                        head_valid <= 1'b0;
                        head_last  <= 1'b0;
                        skid_valid <= 1'b0;
                        inflight   <= 1'b0;
                        s_ready    <= 1'b1;
                        state      <= RECV;
                    end else begin
                        case ({m_pop, inflight})
                            2'b10: begin
                                head_valid <= skid_valid;
                                head_data  <= skid_data;
                                head_last  <= skid_last;
                                skid_valid <= 1'b0;
                            end
                            2'b11: begin
                                if (skid_valid) begin
                                    head_data  <= skid_data;
                                    head_last  <= skid_last;
                                    skid_data  <= tx_rdata;
                                    skid_last  <= inflight_last;
                                end else begin
                                    head_data  <= tx_rdata;
                                    head_last  <= inflight_last;
                                end
                                head_valid <= 1'b1;
                            end
                            2'b01: begin
                                if (!head_valid) begin
                                    head_valid <= 1'b1;
                                    head_data  <= tx_rdata;
                                    head_last  <= inflight_last;
                                end else begin
                                    skid_valid <= 1'b1;
                                    skid_data  <= tx_rdata;
                                    skid_last  <= inflight_last;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end

                RECV: begin
                    if (s_take) begin
                        rx_count <= rx_count + 1'b1;
                        // Packet ends on TLAST or on the last slot; any
                        // disagreement between the two is an error.
                        if (S_AXIS_TLAST || (rx_count == RX_LAST)) begin
                            if (!(S_AXIS_TLAST && (rx_count == RX_LAST))) begin
                                error <= 1'b1;
                            end
                            s_ready <= 1'b0;
                            done    <= 1'b1;
                            state   <= FINISH;
                        end
                    end
                end

                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase

`ifdef STREAM_DRV_TIMEOUT_EN
            // Counts consecutive cycles without any handshake; expiry
            // overrides whatever the state logic above decided.
            if ((state == SEND) || (state == RECV)) begin
                if (m_pop || s_take) begin
                    wd_count <= '0;
                end else if (wd_count == WD_LIMIT) begin
                    wd_count   <= '0;
                    error      <= 1'b1;
                    head_valid <= 1'b0;
                    head_last  <= 1'b0;
                    skid_valid <= 1'b0;
                    inflight   <= 1'b0;
                    s_ready    <= 1'b0;
                    done       <= 1'b1;
                    state      <= FINISH;
                end else begin
                    wd_count <= wd_count + 1'b1;
                end
            end else begin
                wd_count <= '0;
            end
`endif
        end
    end

    memory_RAM #(
        .data_width (WIDTH),
        .depth_bits (TX_ADDR_BITS)
    ) u_tx_ram (
        .clock (ACLK),
        .we    (ld_we && !busy),
        .waddr (ld_addr),
        .wdata (ld_data),
        .raddr (issue_ptr[TX_ADDR_BITS-1:0]),
        .rdata (tx_rdata)
    );

    memory_RAM #(
        .data_width (WIDTH),
        .depth_bits (RX_ADDR_BITS)
    ) u_rx_ram (
        .clock (ACLK),
        .we    (s_take),
        .waddr (rx_count),
        .wdata (S_AXIS_TDATA[WIDTH-1:0]),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_stream_host_driver.sv
// Testbench for stream_host_driver.
//
// The reference model holds the TX buffer contents and the reply words in
// arrays; each transaction pushes the expected outgoing beats into a
// queue that an independent monitor pops on every master handshake.
// Result-buffer reads are queued the same way and checked by a second
// monitor. Timeout scenarios run only when STREAM_DRV_TIMEOUT_EN is set.
module tb_stream_host_driver;

    localparam int W      = 8;
    localparam int NUM_TX = 467;
    localparam int NUM_RX = 64;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        start;
    logic        busy;
    logic        done;
    logic        error;
    logic        ld_we;
    logic [8:0]  ld_addr;
    logic [W-1:0] ld_data;
    logic [5:0]  rd_addr;
    logic [W-1:0] rd_data;
    logic        M_AXIS_TVALID;
    logic [31:0] M_AXIS_TDATA;
    logic        M_AXIS_TLAST;
    logic        M_AXIS_TREADY;
    logic        S_AXIS_TVALID;
    logic [31:0] S_AXIS_TDATA;
    logic        S_AXIS_TLAST;
    logic        S_AXIS_TREADY;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    logic [W-1:0] tx_mem [NUM_TX];
    logic [31:0]  resp_data [NUM_RX];
    logic [W-1:0] rx_exp [NUM_RX];
    beat_t        tx_q [$];
    logic [W-1:0] rd_q [$];

    // Environment state
    int cyc = 0;
    int tready_mode = 0;
    int resp_tlast_idx = 63;
    bit resp_gaps = 1'b0;
    bit resp_active = 1'b0;
    int resp_idx = 0;
    int s_beats = 0;
    int pkt_beats = 0;
    int first_beat_cyc = 0;
    int last_beat_cyc = 0;
    bit first_valid_seen = 1'b0;
    int first_valid_cyc = 0;
    int start_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    bit rd_req = 1'b0;

    stream_host_driver dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .ld_we         (ld_we),
        .ld_addr       (ld_addr),
        .ld_data       (ld_data),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TREADY (S_AXIS_TREADY)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        forever begin
            @(posedge ACLK);
            cyc++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Master-side back-pressure: 0 = always ready, 1 = random, 2 = never.
    initial begin
        M_AXIS_TREADY = 1'b0;
        forever begin
            @(posedge ACLK);
            #1;
            case (tready_mode)
                0:       M_AXIS_TREADY = 1'b1;
                1:       M_AXIS_TREADY = 1'($urandom_range(0, 1));
                default: M_AXIS_TREADY = 1'b0;
            endcase
        end
    end

    // Reply source: offers resp_data words in order, holding each word
    // until it is accepted, optionally inserting idle gaps between words.
    initial begin
        bit hs;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TDATA  = '0;
        S_AXIS_TLAST  = 1'b0;
        forever begin
            @(negedge ACLK);
            hs = S_AXIS_TVALID && S_AXIS_TREADY && ARESETN;
            @(posedge ACLK);
            #1;
            if (hs) begin
                resp_idx++;
                s_beats++;
            end
            if (resp_active && (resp_idx < NUM_RX) &&
                ((S_AXIS_TVALID && !hs) || !resp_gaps || ($urandom_range(0, 3) != 0))) begin
                S_AXIS_TVALID = 1'b1;
                S_AXIS_TDATA  = resp_data[resp_idx];
                S_AXIS_TLAST  = (resp_idx == resp_tlast_idx);
            end else begin
                S_AXIS_TVALID = 1'b0;
                S_AXIS_TLAST  = 1'b0;
            end
        end
    end

    // Master-port monitor: scoreboard pop, stability while stalled,
    // idle-output checks, beat timing.
    initial begin
        bit          stall_prev;
        logic [31:0] held_data;
        logic        held_last;
        beat_t       e;
        stall_prev = 1'b0;
        held_data  = '0;
        held_last  = 1'b0;
        forever begin
            @(negedge ACLK);
            if (!ARESETN) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    checkOutput("tvalid_hold", 32'(M_AXIS_TVALID), 32'd1);
                    checkOutput("tdata_hold", M_AXIS_TDATA, held_data);
                    checkOutput("tlast_hold", 32'(M_AXIS_TLAST), 32'(held_last));
                end
                if (!busy) begin
                    checkOutput("tvalid_idle", 32'(M_AXIS_TVALID), 32'd0);
                    checkOutput("s_tready_idle", 32'(S_AXIS_TREADY), 32'd0);
                end
                if (M_AXIS_TVALID && !first_valid_seen) begin
                    first_valid_seen = 1'b1;
                    first_valid_cyc  = cyc;
                end
                if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                    checkOutput("tx_beat_expected", 32'(tx_q.size() != 0), 32'd1);
                    if (tx_q.size() != 0) begin
                        e = tx_q.pop_front();
                        checkOutput("tx_data", M_AXIS_TDATA, e.data);
                        checkOutput("tx_last", 32'(M_AXIS_TLAST), 32'(e.last));
                    end
                    if (pkt_beats == 0) first_beat_cyc = cyc;
                    last_beat_cyc = cyc;
                    pkt_beats++;
                end
                stall_prev = M_AXIS_TVALID && !M_AXIS_TREADY;
                held_data  = M_AXIS_TDATA;
                held_last  = M_AXIS_TLAST;
            end
        end
    end

    // Done-pulse counter and result-buffer read monitor.
    initial begin
        bit          rd_check_next;
        logic [W-1:0] e;
        rd_check_next = 1'b0;
        forever begin
            @(negedge ACLK);
            if (ARESETN && done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (rd_check_next) begin
                checkOutput("rd_expected", 32'(rd_q.size() != 0), 32'd1);
                if (rd_q.size() != 0) begin
                    e = rd_q.pop_front();
                    checkOutput("rd_data", 32'(rd_data), 32'(e));
                end
            end
            rd_check_next = rd_req;
        end
    end

    task automatic load_tx(input bit pattern);
        for (int i = 0; i < NUM_TX; i++) begin
            @(posedge ACLK);
            #1;
            ld_we   = 1'b1;
            ld_addr = 9'(i);
            ld_data = pattern ? W'(i) : W'($urandom);
            tx_mem[i] = ld_data;
        end
        @(posedge ACLK);
        #1;
        ld_we = 1'b0;
    endtask

    // Builds the expected outgoing packet and reply, then pulses start.
    task automatic applyStimulus(input int tlast_idx, input bit gaps,
                                 input int tmode, input bit pattern);
        beat_t b;
        tx_q.delete();
        for (int i = 0; i < NUM_TX; i++) begin
            b.data = 32'(tx_mem[i]);
            b.last = (i == NUM_TX - 1);
            tx_q.push_back(b);
        end
        for (int i = 0; i < NUM_RX; i++) begin
            resp_data[i] = pattern ? (32'h10 + 32'(i)) : $urandom;
            rx_exp[i]    = resp_data[i][W-1:0];
        end
        resp_tlast_idx   = tlast_idx;
        resp_gaps        = gaps;
        resp_idx         = 0;
        s_beats          = 0;
        resp_active      = 1'b1;
        tready_mode      = tmode;
        pkt_beats        = 0;
        first_valid_seen = 1'b0;
        @(posedge ACLK);
        #1;
        start = 1'b1;
        @(posedge ACLK);
        #1;
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int budget);
        int start_cnt;
        int n;
        start_cnt = done_cnt;
        n = 0;
        while ((done_cnt == start_cnt) && (n < budget)) begin
            @(posedge ACLK);
            #1;
            n++;
        end
        checkOutput("done_seen", 32'(done_cnt != start_cnt), 32'd1);
        repeat (3) begin
            @(posedge ACLK);
            #1;
        end
        checkOutput("done_once", 32'(done_cnt - start_cnt), 32'd1);
        checkOutput("busy_after_done", 32'(busy), 32'd0);
    endtask

    task automatic readback(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge ACLK);
            #1;
            rd_addr = 6'(i);
            rd_req  = 1'b1;
            rd_q.push_back(rx_exp[i]);
        end
        @(posedge ACLK);
        #1;
        rd_req = 1'b0;
        repeat (2) begin
            @(posedge ACLK);
            #1;
        end
        checkOutput("rd_all_checked", 32'(rd_q.size()), 32'd0);
    endtask

    task automatic end_packet();
        resp_active = 1'b0;
        tready_mode = 0;
        checkOutput("tx_all_sent", 32'(tx_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        #800000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int n;
        ARESETN = 1'b0;
        start   = 1'b0;
        ld_we   = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        rd_addr = '0;
        repeat (3) @(posedge ACLK);
        #1;
        checkOutput("rst_tvalid", 32'(M_AXIS_TVALID), 32'd0);
        checkOutput("rst_tlast", 32'(M_AXIS_TLAST), 32'd0);
        checkOutput("rst_s_tready", 32'(S_AXIS_TREADY), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_error", 32'(error), 32'd0);
        ARESETN = 1'b1;

        // Index pattern, full-rate sink, clean 0x10+i reply.
        load_tx(1'b1);
        applyStimulus(63, 1'b0, 0, 1'b1);
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        wait_done(3000);
        checkOutput("t1_first_valid_latency", 32'((first_valid_cyc - start_cyc) <= 2), 32'd1);
        checkOutput("t1_beats", 32'(pkt_beats), 32'(NUM_TX));
        checkOutput("t1_back_to_back", 32'(last_beat_cyc - first_beat_cyc), 32'(NUM_TX - 1));
        checkOutput("t1_error", 32'(error), 32'd0);
        checkOutput("t1_rx_words", 32'(s_beats), 32'(NUM_RX));
        end_packet();
        readback(NUM_RX);

        // Early TLAST on reply word 10.
        applyStimulus(10, 1'b1, 1, 1'b0);
        wait_done(6000);
        checkOutput("t3_error", 32'(error), 32'd1);
        checkOutput("t3_rx_words", 32'(s_beats), 32'd11);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t3_s_tready_low", 32'(S_AXIS_TREADY), 32'd0);
            @(posedge ACLK);
            #1;
        end
        checkOutput("t3_error_sticky", 32'(error), 32'd1);
        end_packet();
        readback(11);

        // Random data, random back-pressure, gappy reply; a load while
        // busy must not disturb the packet.
        load_tx(1'b0);
        applyStimulus(63, 1'b1, 1, 1'b0);
        checkOutput("t2_error_cleared", 32'(error), 32'd0);
        @(posedge ACLK);
        #1;
        ld_we   = 1'b1;
        ld_addr = 9'd400;
        ld_data = ~tx_mem[400];
        @(posedge ACLK);
        #1;
        ld_we = 1'b0;
        wait_done(6000);
        checkOutput("t2_beats", 32'(pkt_beats), 32'(NUM_TX));
        checkOutput("t2_error", 32'(error), 32'd0);
        end_packet();
        readback(NUM_RX);

        // Reply word 63 arrives without TLAST.
        applyStimulus(100, 1'b0, 0, 1'b0);
        wait_done(3000);
        checkOutput("t4_error", 32'(error), 32'd1);
        checkOutput("t4_rx_words", 32'(s_beats), 32'(NUM_RX));
        end_packet();

        // Reset in the middle of the outgoing packet, then a clean rerun.
        applyStimulus(63, 1'b0, 1, 1'b0);
        n = 0;
        while ((pkt_beats < 200) && (n < 4000)) begin
            @(posedge ACLK);
            #1;
            n++;
        end
        checkOutput("t5_reached_word_200", 32'(pkt_beats >= 200), 32'd1);
        ARESETN = 1'b0;
        @(posedge ACLK);
        #1;
        checkOutput("t5_rst_tvalid", 32'(M_AXIS_TVALID), 32'd0);
        checkOutput("t5_rst_tlast", 32'(M_AXIS_TLAST), 32'd0);
        checkOutput("t5_rst_s_tready", 32'(S_AXIS_TREADY), 32'd0);
        checkOutput("t5_rst_busy", 32'(busy), 32'd0);
        checkOutput("t5_rst_done", 32'(done), 32'd0);
        checkOutput("t5_rst_error", 32'(error), 32'd0);
        tx_q.delete();
        resp_active = 1'b0;
        ARESETN = 1'b1;
        applyStimulus(63, 1'b1, 1, 1'b0);
        wait_done(6000);
        checkOutput("t5_beats", 32'(pkt_beats), 32'(NUM_TX));
        checkOutput("t5_error", 32'(error), 32'd0);
        end_packet();
        readback(NUM_RX);

`ifdef STREAM_DRV_TIMEOUT_EN
        // Sink never ready: the watchdog must abort the transaction.
        applyStimulus(63, 1'b0, 2, 1'b0);
        wait_done(3000);
        checkOutput("t6_error", 32'(error), 32'd1);
        checkOutput("t6_tvalid", 32'(M_AXIS_TVALID), 32'd0);
        checkOutput("t6_beats", 32'(pkt_beats), 32'd0);
        checkOutput("t6_abort_time", 32'(((done_cyc - start_cyc) >= 1024) &&
                                         ((done_cyc - start_cyc) <= 1026)), 32'd1);
        tx_q.delete();
        resp_active = 1'b0;
        tready_mode = 0;
`endif

        repeat (2) @(posedge ACLK);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/stream_host_driver.md
STREAM_HOST_DRIVER -- requirements
Module: stream_host_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning payload bits per word; carried in TDATA[WIDTH-1:0], upper bits zero.
REQ-002 SHALL have parameter NUM_TX_WORDS, default 467, meaning words per outgoing packet.
REQ-003 SHALL have parameter NUM_RX_WORDS, default 64, meaning words per returned packet.
REQ-004 SHALL have port ACLK  in  1  clock; reset ARESETN, synchronous, active-low.
REQ-005 SHALL have port ARESETN  in  1  synchronous active-low reset.
REQ-006 SHALL have ports start in 1 (pulse begins transaction), busy out 1, done out 1 (one-cycle pulse), error out 1 (sticky until next start).
REQ-007 SHALL have load port ld_we in 1, ld_addr in 9, ld_data in WIDTH: writes TX buffer; ignored while busy.
REQ-008 SHALL have result port rd_addr in 6, rd_data out WIDTH: RX buffer read, 1-cycle latency.
REQ-009 SHALL have master ports M_AXIS_TVALID out 1, M_AXIS_TDATA out 32, M_AXIS_TLAST out 1, M_AXIS_TREADY in 1.
REQ-010 SHALL have slave ports S_AXIS_TVALID in 1, S_AXIS_TDATA in 32, S_AXIS_TLAST in 1, S_AXIS_TREADY out 1.

Function
REQ-011 SHALL implement states IDLE, SEND, RECV, FINISH.
REQ-012 IDLE -> SEND on start=1; start ignored outside IDLE.
REQ-013 SEND SHALL transmit TX buffer addresses 0..NUM_TX_WORDS-1 in order; transfer occurs only on TVALID&&TREADY.
REQ-014 Once TVALID=1, TVALID, TDATA, TLAST SHALL hold stable until handshake; TVALID never depends combinationally on TREADY.
REQ-015 SHALL sustain one word per cycle while TREADY=1 (prefetch / two-entry output buffer to hide 1-cycle RAM latency).
REQ-016 First TVALID SHALL assert no later than 2 cycles after start accepted.
REQ-017 TLAST SHALL be 1 exactly on word NUM_TX_WORDS-1; after its handshake TVALID drops next cycle and state -> RECV.
REQ-018 RECV SHALL drive S_AXIS_TREADY=1 and write S_AXIS_TDATA[WIDTH-1:0] to RX buffer at rx_count on each S handshake; rx_count increments.
REQ-019 S_AXIS_TLAST on word index NUM_RX_WORDS-1 SHALL -> FINISH; TLAST earlier, or missing on that word, SHALL set error and -> FINISH.
REQ-020 Words after an erroneous packet end SHALL not be accepted (TREADY=0 from FINISH on).
REQ-021 FINISH SHALL pulse done for one cycle, then -> IDLE; busy=1 in SEND, RECV, FINISH.
REQ-022 S_AXIS_TREADY SHALL be 0 outside RECV; M_AXIS_TVALID SHALL be 0 outside SEND.
REQ-023 TREADY low for any number of cycles mid-packet SHALL not skip or repeat a word.

Reset
REQ-024 ARESETN=0 SHALL force IDLE, counters 0, M_AXIS_TVALID=0, M_AXIS_TLAST=0, S_AXIS_TREADY=0, busy=0, done=0, error=0, mid-transaction included; buffer contents undefined-preserved.

Configuration
REQ-025 With STREAM_DRV_TIMEOUT_EN defined, a parameter TIMEOUT_CYCLES (default 1024) watchdog SHALL count cycles without a handshake in SEND or RECV; on reaching limit set error, deassert TVALID/TREADY, -> FINISH.
REQ-026 Without STREAM_DRV_TIMEOUT_EN, no watchdog logic SHALL exist and the block waits indefinitely.

Structure
REQ-027 Shared package stream_drv_pkg SHALL hold the state encoding and default word-count/width constants.
REQ-028 TX and RX buffers SHALL be instances of the existing memory_RAM (depth_bits 9 and 6); no other sub-module.

Verification
REQ-029 Load 0..466 mod 256, start, TREADY=1 constant -> 467 consecutive-cycle beats, data = index mod 256, TLAST only on beat 466.
REQ-030 TREADY toggled random 50% during SEND -> identical 467-word sequence, TDATA stable while stalled, no duplicates.
REQ-031 Responder returns 64 words 0x10+i with TLAST on i=63 -> rd_addr i reads 0x10+i, done pulses once, error=0.
REQ-032 Responder asserts TLAST on word 10 -> error=1, done pulse, S_AXIS_TREADY=0 afterward.
REQ-033 ARESETN low during SEND word 200 -> next cycle all outputs at reset values; new start sends from word 0.
REQ-034 With STREAM_DRV_TIMEOUT_EN, TREADY held 0 for 1024 cycles in SEND -> error=1, TVALID=0, done pulse.
